// File: rtl/axi2ahb_pkg.sv
// Shared definitions for the AXI-to-AHB bridge (aclk and hclk sides).
package axi2ahb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 3;

  // Entry pushed into the state FIFO; the hclk consumer decodes these.
  localparam logic STATE_WRITE = 1'b1;
  localparam logic STATE_READ  = 1'b0;

  // Round-robin arbiter state: which request type won last.
  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_e;

  // Only single-beat transfers are supported; anything else is flagged.
  function automatic logic is_burst(input logic [7:0] len);
    return (len != 8'd0);
  endfunction

endpackage

// File: rtl/req_hold_reg.sv
// Single-entry valid/ready holding register.
// Handshake: a transfer happens on a rising clk edge where in_valid and
// in_ready are both high; in_ready is high whenever the register is empty or
// its content is being consumed in the same cycle, so a new value can load
// while the old one leaves and the valid flag stays set.
module req_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         consume,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || consume;

  // Load on handshake, drop valid when consumed without a replacement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi_req_sched.sv
// AXI-side request scheduler (aclk domain) of the AXI-to-AHB bridge.
// Holds single-beat AW+W writes and AR reads, arbitrates round-robin between
// write and read, and pushes each winner atomically into the addr, data,
// state, id_send and size FIFOs.
// Optional: define AXI_REQ_SCHED_PERF_EN to add push/stall counters.
// Channel handshakes follow AXI valid/ready: a beat transfers on the rising
// aclk edge where valid and ready are both high; ready never waits on valid.
import axi2ahb_pkg::*;

module axi_req_sched #(
  parameter int AXI_ID_WIDTH = 8
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [AXI_ID_WIDTH-1:0] awid,
  input  logic [ADDR_W-1:0]       awaddr,
  input  logic [7:0]              awlen,
  input  logic [SIZE_W-1:0]       awsize,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    wlast,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [AXI_ID_WIDTH-1:0] arid,
  input  logic [ADDR_W-1:0]       araddr,
  input  logic [7:0]              arlen,
  input  logic [SIZE_W-1:0]       arsize,
  output logic [ADDR_W-1:0]       axi_addr,
  output logic                    addr_w_en,
  input  logic                    addr_fifo_full,
  output logic [DATA_W-1:0]       axi_data,
  output logic                    data_w_en,
  input  logic                    data_fifo_full,
  output logic                    axi_write,
  output logic                    state_w_en,
  input  logic                    state_fifo_full,
  output logic [AXI_ID_WIDTH:0]   axi_id,
  output logic                    id_send_w_en,
  input  logic                    id_send_fifo_full,
  output logic [SIZE_W-1:0]       axi_size,
  output logic                    size_w_en,
  input  logic                    size_fifo_full,
  output logic                    err_burst,
  output grant_e                  dbg_last_grant
`ifdef AXI_REQ_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_wr_cnt,
  output logic [31:0]             perf_rd_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  localparam int REQ_W = AXI_ID_WIDTH + ADDR_W + SIZE_W;

  logic             aw_h_v, w_h_v, ar_h_v;
  logic [REQ_W-1:0] aw_h_d, ar_h_d;
  logic [DATA_W-1:0] w_h_d;
  logic             grant_wr, grant_rd;
  logic             wr_cand, rd_cand, wr_ok, rd_ok, wr_elig, rd_elig;
  grant_e           last_grant, last_grant_nxt;

  // Holding registers: AW and W consumed together, AR on its own.
  req_hold_reg #(.W(REQ_W)) u_aw_h (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(awvalid), .in_data({awid, awaddr, awsize}), .in_ready(awready),
    .consume(grant_wr), .out_valid(aw_h_v), .out_data(aw_h_d)
  );

  req_hold_reg #(.W(DATA_W)) u_w_h (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(wvalid), .in_data(wdata), .in_ready(wready),
    .consume(grant_wr), .out_valid(w_h_v), .out_data(w_h_d)
  );

  req_hold_reg #(.W(REQ_W)) u_ar_h (
    .clk(aclk), .rst_n(aresetn),
    .in_valid(arvalid), .in_data({arid, araddr, arsize}), .in_ready(arready),
    .consume(grant_rd), .out_valid(ar_h_v), .out_data(ar_h_d)
  );

  // A request is eligible only if every FIFO it writes has room; a read
  // never needs the data FIFO, so a full data FIFO cannot stall reads.
  assign wr_cand = aw_h_v && w_h_v;
  assign rd_cand = ar_h_v;
  assign wr_ok   = !(addr_fifo_full || data_fifo_full || state_fifo_full ||
                     id_send_fifo_full || size_fifo_full);
  assign rd_ok   = !(addr_fifo_full || state_fifo_full ||
                     id_send_fifo_full || size_fifo_full);
  assign wr_elig = wr_cand && wr_ok;
  assign rd_elig = rd_cand && rd_ok;

  assign dbg_last_grant = last_grant;

  // Round-robin state: remembers the type of the most recent grant.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) last_grant <= GRANT_RD;
    else          last_grant <= last_grant_nxt;
  end

  // Grant selection: alternate under contention, otherwise take whoever is eligible.
  always_comb begin
    grant_wr       = 1'b0;
    grant_rd       = 1'b0;
    last_grant_nxt = last_grant;
    if (wr_elig && (!rd_elig || last_grant == GRANT_RD)) begin
      grant_wr       = 1'b1;
      last_grant_nxt = GRANT_WR;
    end else if (rd_elig) begin
      grant_rd       = 1'b1;
      last_grant_nxt = GRANT_RD;
    end
  end

  // Registered FIFO push: all strobes of one request pulse together.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_w_en    <= 1'b0;
      data_w_en    <= 1'b0;
      state_w_en   <= 1'b0;
      id_send_w_en <= 1'b0;
      size_w_en    <= 1'b0;
      axi_addr     <= '0;
      axi_data     <= '0;
      axi_write    <= 1'b0;
      axi_id       <= '0;
      axi_size     <= '0;
    end else begin
      addr_w_en    <= grant_wr || grant_rd;
      data_w_en    <= grant_wr;
      state_w_en   <= grant_wr || grant_rd;
      id_send_w_en <= grant_wr || grant_rd;
      size_w_en    <= grant_wr || grant_rd;
      if (grant_wr) begin
        axi_addr  <= aw_h_d[SIZE_W +: ADDR_W];
        axi_data  <= w_h_d;
        axi_write <= STATE_WRITE;
        axi_id    <= {STATE_WRITE, aw_h_d[SIZE_W+ADDR_W +: AXI_ID_WIDTH]};
        axi_size  <= aw_h_d[SIZE_W-1:0];
      end else if (grant_rd) begin
        axi_addr  <= ar_h_d[SIZE_W +: ADDR_W];
        axi_write <= STATE_READ;
        axi_id    <= {STATE_READ, ar_h_d[SIZE_W+ADDR_W +: AXI_ID_WIDTH]};
        axi_size  <= ar_h_d[SIZE_W-1:0];
      end
    end
  end

  // Sticky protocol error: bursts are accepted but treated as single beats.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_burst <= 1'b0;
    end else if ((awvalid && awready && is_burst(awlen)) ||
                 (wvalid && wready && !wlast) ||
                 (arvalid && arready && is_burst(arlen))) begin
      err_burst <= 1'b1;
    end
  end

`ifdef AXI_REQ_SCHED_PERF_EN
  logic stall;
  assign stall = (wr_cand && !wr_ok) || (rd_cand && !rd_ok);

  // Performance counters, free-running and wrapping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_wr_cnt    <= '0;
      perf_rd_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (grant_wr) perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (grant_rd) perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_req_sched.sv
// Testbench for axi_req_sched: directed scenarios plus a randomized phase,
// checked against per-type expected queues of accepted requests.
module tb_axi_req_sched;

  logic        aclk, aresetn;
  logic        awvalid, awready, wvalid, wready, arvalid, arready;
  logic [7:0]  awid, arid, awlen, arlen;
  logic [31:0] awaddr, araddr;
  logic [2:0]  awsize, arsize;
  logic [63:0] wdata;
  logic        wlast;
  logic [31:0] axi_addr;
  logic [63:0] axi_data;
  logic [8:0]  axi_id;
  logic [2:0]  axi_size;
  logic        axi_write, err_burst;
  logic        addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en;
  logic        addr_fifo_full, data_fifo_full, state_fifo_full;
  logic        id_send_fifo_full, size_fifo_full;
  axi2ahb_pkg::grant_e dbg_last_grant;

  // Scoreboard: accepted requests per channel, in acceptance order.
  logic [42:0] aw_exp_q[$];
  logic [63:0] w_exp_q[$];
  logic [42:0] ar_exp_q[$];
  logic        push_log[$];
  int          n_wr, n_rd;
  int          n_checks, n_pass;

  axi_req_sched #(.AXI_ID_WIDTH(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arsize(arsize),
    .axi_addr(axi_addr), .addr_w_en(addr_w_en), .addr_fifo_full(addr_fifo_full),
    .axi_data(axi_data), .data_w_en(data_w_en), .data_fifo_full(data_fifo_full),
    .axi_write(axi_write), .state_w_en(state_w_en), .state_fifo_full(state_fifo_full),
    .axi_id(axi_id), .id_send_w_en(id_send_w_en), .id_send_fifo_full(id_send_fifo_full),
    .axi_size(axi_size), .size_w_en(size_w_en), .size_fifo_full(size_fifo_full),
    .err_burst(err_burst), .dbg_last_grant(dbg_last_grant)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr,
                         input logic [2:0] size, input logic [7:0] len);
    int t;
    bit ok;
    awid = id; awaddr = addr; awsize = size; awlen = len; awvalid = 1'b1;
    t = 0; ok = 1'b1;
    forever begin
      @(negedge aclk);
      if (awready) break;
      t++;
      if (t > 2000) begin check("aw_timeout", 64'(1), 64'(0)); ok = 1'b0; break; end
    end
    if (ok) aw_exp_q.push_back({id, addr, size});
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] data, input logic last);
    int t;
    bit ok;
    wdata = data; wlast = last; wvalid = 1'b1;
    t = 0; ok = 1'b1;
    forever begin
      @(negedge aclk);
      if (wready) break;
      t++;
      if (t > 2000) begin check("w_timeout", 64'(1), 64'(0)); ok = 1'b0; break; end
    end
    if (ok) w_exp_q.push_back(data);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b1;
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                         input logic [2:0] size, input logic [7:0] len);
    int t;
    bit ok;
    arid = id; araddr = addr; arsize = size; arlen = len; arvalid = 1'b1;
    t = 0; ok = 1'b1;
    forever begin
      @(negedge aclk);
      if (arready) break;
      t++;
      if (t > 2000) begin check("ar_timeout", 64'(1), 64'(0)); ok = 1'b0; break; end
    end
    if (ok) ar_exp_q.push_back({id, addr, size});
    @(posedge aclk); #1;
    arvalid = 1'b0;
  endtask

  task automatic set_full(input logic [4:0] f);
    {addr_fifo_full, data_fifo_full, state_fifo_full, id_send_fifo_full, size_fifo_full} = f;
  endtask

  // ---------------- push monitor / scoreboard ----------------
  always @(negedge aclk) begin
    if (aresetn && (addr_w_en || data_w_en || state_w_en || id_send_w_en || size_w_en)) begin
      logic [42:0] a;
      logic [63:0] d;
      check("strobe_set", 64'({addr_w_en, state_w_en, id_send_w_en, size_w_en}), 64'(4'hf));
      if (axi_write) begin
        check("wr_data_en", 64'(data_w_en), 64'(1));
        if (aw_exp_q.size() == 0 || w_exp_q.size() == 0) begin
          check("wr_extra_push", 64'(1), 64'(0));
        end else begin
          a = aw_exp_q.pop_front();
          d = w_exp_q.pop_front();
          check("wr_id", 64'(axi_id), 64'({1'b1, a[42:35]}));
          check("wr_addr", 64'(axi_addr), 64'(a[34:3]));
          check("wr_size", 64'(axi_size), 64'(a[2:0]));
          check("wr_data", axi_data, d);
        end
        n_wr++;
      end else begin
        check("rd_data_en", 64'(data_w_en), 64'(0));
        if (ar_exp_q.size() == 0) begin
          check("rd_extra_push", 64'(1), 64'(0));
        end else begin
          a = ar_exp_q.pop_front();
          check("rd_id", 64'(axi_id), 64'({1'b0, a[42:35]}));
          check("rd_addr", 64'(axi_addr), 64'(a[34:3]));
          check("rd_size", 64'(axi_size), 64'(a[2:0]));
        end
        n_rd++;
      end
      push_log.push_back(axi_write);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int base, stray;
    bit rand_done;
    n_checks = 0; n_pass = 0; n_wr = 0; n_rd = 0;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
    wvalid = 0; wdata = 0; wlast = 1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
    set_full(5'b0);
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Reset state
    @(negedge aclk);
    check("rst_strobes", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'(0));
    check("rst_err", 64'(err_burst), 64'(0));
    check("rst_ready", 64'({awready, wready, arready}), 64'(3'b111));
    check("rst_last_grant", 64'(dbg_last_grant), 64'(0));
    check("rst_outputs", 64'({axi_addr, axi_id, axi_size, axi_write}), 64'(0));
    check("rst_data", axi_data, 64'(0));
    step(1);

    // Single write, W three cycles after AW, then 2-cycle latency to strobes
    send_aw(8'h05, 32'h1000, 3'd3, 8'd0);
    step(2);
    send_w(64'hDEADBEEF_CAFEF00D, 1'b1);
    @(negedge aclk);
    check("wr_lat_early", 64'(addr_w_en), 64'(0));
    @(negedge aclk);
    check("wr_lat_strobes", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'(5'h1f));
    check("wr_axi_id", 64'(axi_id), 64'(9'h105));
    check("wr_axi_write", 64'(axi_write), 64'(1));
    @(negedge aclk);
    check("wr_one_pulse", 64'(addr_w_en), 64'(0));
    check("wr_count", 64'(n_wr), 64'(1));
    step(1);

    // Single read
    send_ar(8'h0A, 32'h2000, 3'd2, 8'd0);
    step(3);
    check("rd_count", 64'(n_rd), 64'(1));

    // Contention: 4 writes and 4 reads offered together
    push_log.delete();
    fork
      for (int i = 0; i < 4; i++) send_aw(8'(8'h10 + i), 32'h3000 + 32'(i * 8), 3'd3, 8'd0);
      for (int i = 0; i < 4; i++) send_w({$urandom, $urandom}, 1'b1);
      for (int i = 0; i < 4; i++) send_ar(8'(8'h20 + i), 32'h4000 + 32'(i * 4), 3'd2, 8'd0);
    join
    step(4);
    check("rr_count", 64'(push_log.size()), 64'(8));
    for (int i = 0; i < 8 && i < push_log.size(); i++)
      check($sformatf("rr_order_%0d", i), 64'(push_log[i]), 64'((i % 2) == 0));

    // Data FIFO full: read bypasses the blocked write
    push_log.delete();
    set_full(5'b01000);
    fork
      send_aw(8'h33, 32'h5000, 3'd3, 8'd0);
      send_w(64'h1122334455667788, 1'b1);
      send_ar(8'h44, 32'h6000, 3'd1, 8'd0);
    join
    step(3);
    @(negedge aclk);
    check("byp_count", 64'(push_log.size()), 64'(1));
    if (push_log.size() > 0) check("byp_is_read", 64'(push_log[0]), 64'(0));
    check("byp_wready", 64'(wready), 64'(0));
    check("byp_awready", 64'(awready), 64'(0));
    step(1);
    set_full(5'b0);
    @(negedge aclk);
    @(negedge aclk);
    check("byp_wr_pushed", 64'({addr_w_en, axi_write}), 64'(2'b11));
    step(2);

    // Backpressure: addr FIFO full for 10 cycles
    base = n_wr + n_rd;
    stray = 0;
    set_full(5'b10000);
    fork
      begin send_aw(8'h51, 32'h7000, 3'd3, 8'd0); send_aw(8'h52, 32'h7008, 3'd3, 8'd0); end
      begin send_w(64'hA5A5, 1'b1); send_w(64'h5A5A, 1'b1); end
      begin send_ar(8'h61, 32'h8000, 3'd2, 8'd0); send_ar(8'h62, 32'h8004, 3'd2, 8'd0); end
    join_none
    repeat (10) begin
      @(negedge aclk);
      if (addr_w_en || state_w_en) stray++;
    end
    check("bp_no_strobes", 64'(stray), 64'(0));
    check("bp_ready_low", 64'({awready, wready, arready}), 64'(0));
    step(1);
    set_full(5'b0);
    wait fork;
    step(5);
    check("bp_pushes", 64'(n_wr + n_rd - base), 64'(4));
    check("bp_queues_empty", 64'(aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size()), 64'(0));

    // Randomized traffic with random FIFO-full backpressure
    rand_done = 0;
    fork
      begin
        fork
          for (int i = 0; i < 40; i++) begin
            step($urandom_range(1, 3));
            send_aw(8'($urandom), $urandom, 3'($urandom_range(0, 3)), 8'd0);
          end
          for (int i = 0; i < 40; i++) begin
            step($urandom_range(1, 4));
            send_w({$urandom, $urandom}, 1'b1);
          end
          for (int i = 0; i < 40; i++) begin
            step($urandom_range(1, 3));
            send_ar(8'($urandom), $urandom, 3'($urandom_range(0, 3)), 8'd0);
          end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge aclk); #1;
          addr_fifo_full    = ($urandom_range(0, 5) == 0);
          data_fifo_full    = ($urandom_range(0, 3) == 0);
          state_fifo_full   = ($urandom_range(0, 7) == 0);
          id_send_fifo_full = ($urandom_range(0, 7) == 0);
          size_fifo_full    = ($urandom_range(0, 7) == 0);
        end
        set_full(5'b0);
      end
    join
    for (int t = 0; t < 100 && (aw_exp_q.size() + ar_exp_q.size()) != 0; t++) step(1);
    step(2);
    check("rand_drained", 64'(aw_exp_q.size() + w_exp_q.size() + ar_exp_q.size()), 64'(0));
    check("rand_no_err", 64'(err_burst), 64'(0));

    // Burst length error: flagged but pushed as one beat
    base = n_wr;
    fork
      send_aw(8'h77, 32'h9000, 3'd3, 8'd3);
      send_w(64'hFEEDFACE, 1'b1);
    join
    step(4);
    check("err_set", 64'(err_burst), 64'(1));
    check("err_single_push", 64'(n_wr - base), 64'(1));

    // Asynchronous reset while a strobe is high and an AW is held
    set_full(5'b10000);
    fork
      send_aw(8'h88, 32'hA000, 3'd3, 8'd0);
      send_ar(8'h99, 32'hB000, 3'd2, 8'd0);
    join
    set_full(5'b0);
    step(1);
    check("rst_pre_strobe", 64'(addr_w_en), 64'(1));
    #1 aresetn = 1'b0;
    #1;
    check("rst_mid_strobes", 64'({addr_w_en, data_w_en, state_w_en, id_send_w_en, size_w_en}), 64'(0));
    check("rst_mid_err", 64'(err_burst), 64'(0));
    check("rst_mid_holds", 64'({awready, wready, arready}), 64'(3'b111));
    aw_exp_q.delete(); w_exp_q.delete(); ar_exp_q.delete();
    step(1);
    aresetn = 1'b1;
    base = n_wr + n_rd;
    step(1);
    send_w(64'h0BAD, 1'b1);
    step(5);
    check("rst_holds_empty", 64'(n_wr + n_rd - base), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_req_sched.md
Name: axi_req_sched

Overview:
- AXI-side request scheduler in the aclk domain of the AXI-to-AHB bridge.
- Accepts single-beat AXI write (AW+W) and read (AR) requests into holding registers.
- Arbitrates between write and read round-robin.
- Pushes each granted request atomically into the addr, data, state, id_send and size async FIFOs, which the hclk-side AHB master consumes.

Parameters:
- AXI_ID_WIDTH, 8, width of AXI AWID/ARID; id_send FIFO entry is AXI_ID_WIDTH+1.

Ports:
- aclk  in  1  AXI-side clock
- aresetn  in  1  asynchronous active-low reset
- awvalid/awready  in/out  1  AW handshake
- awid  in  AXI_ID_WIDTH  write ID
- awaddr  in  32  write address
- awlen  in  8  burst length (must be 0)
- awsize  in  3  write size
- wvalid/wready  in/out  1  W handshake
- wdata  in  64  write data
- wlast  in  1  last beat (must be 1)
- arvalid/arready  in/out  1  AR handshake
- arid  in  AXI_ID_WIDTH  read ID
- araddr  in  32  read address
- arlen  in  8  burst length (must be 0)
- arsize  in  3  read size
- axi_addr  out  32  addr FIFO write data
- addr_w_en  out  1  addr FIFO push
- addr_fifo_full  in  1  addr FIFO full
- axi_data  out  64  data FIFO write data
- data_w_en  out  1  data FIFO push
- data_fifo_full  in  1  data FIFO full
- axi_write  out  1  state FIFO entry: 1 write, 0 read
- state_w_en  out  1  state FIFO push
- state_fifo_full  in  1  state FIFO full
- axi_id  out  AXI_ID_WIDTH+1  id_send entry {is_write, id}
- id_send_w_en  out  1  id_send FIFO push
- id_send_fifo_full  in  1  id_send FIFO full
- axi_size  out  3  size FIFO entry
- size_w_en  out  1  size FIFO push
- size_fifo_full  in  1  size FIFO full
- err_burst  out  1  sticky: burst or wlast=0 seen

Behaviour:
- Reset:
  - All hold-valid flags, push strobes and err_burst are 0.
  - last_grant = READ, so the first contention grants WRITE.
  - Data outputs are 0.
- Holding registers aw_h, w_h, ar_h, each with a valid flag:
  - Ready rule: xready = !x_h_v || x consumed this cycle.
  - A handshake (xvalid & xready) loads the register on the next edge.
- Candidates:
  - wr_cand = aw_h_v & w_h_v.
  - rd_cand = ar_h_v.
- Resource check:
  - wr_ok = !(addr|data|state|id_send|size)_fifo_full.
  - rd_ok = !(addr|state|id_send|size)_fifo_full.
  - A read never touches the data FIFO.
- Grant (combinational, one per cycle):
  - If both candidates are eligible, grant the opposite of last_grant.
  - Otherwise grant the single eligible one.
  - A candidate blocked by a full FIFO does not block the other type.
  - last_grant updates only on a grant.
- Push (registered outputs, one cycle after the grant edge):
  - All relevant w_en strobes pulse high together for exactly one aclk.
  - axi_write = 1 for write, 0 for read; axi_id = {axi_write, id}; axi_size = xsize.
  - data_w_en asserts only for writes.
  - Partial pushes are never allowed.
- Throughput: one request per cycle at steady state.
- Latency: AW+W handshake to strobes = 2 aclk when uncontended.
- AW/W skew: either channel may arrive first; the hold waits indefinitely for its partner. The next AW is not accepted until the held write is pushed.
- Simultaneous handshake and consume on the same register: the new value loads and the valid flag stays 1.
- Protocol errors:
  - awlen != 0, arlen != 0 or wlast = 0 sets err_burst, which clears only on reset.
  - The request is still pushed as a single beat.
- wstrb is not present; the write width is given solely by awsize.
- Reset mid-operation (asynchronous assert):
  - Holds are discarded and strobes drop immediately.
  - FIFO contents are the FIFO owner's concern.

Optional Feature:
- Macro: AXI_REQ_SCHED_PERF_EN.
- Defined: adds outputs perf_wr_cnt[31:0], perf_rd_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_wr_cnt / perf_rd_cnt increment on each push of their type.
  - perf_stall_cnt increments each cycle any candidate is valid but not granted due to a full FIFO.
  - All counters wrap at 2^32 and reset to 0.
- Undefined: no ports and no counter logic.

Decomposition:
- Shared package axi2ahb_pkg holds:
  - GRANT_WR / GRANT_RD encodings.
  - STATE_WRITE = 1'b1 / STATE_READ = 1'b0 (shared with the hclk consumer).
  - ADDR_W = 32, DATA_W = 64, SIZE_W = 3.
- One natural sub-module: req_hold_reg, a valid/ready holding register parameterised on width, instantiated three times.
- The arbiter stays inline.

Test Plan:
- Single write: AW (id=0x05, addr=0x1000, size=3) then W (data=0xDEADBEEF_CAFEF00D) 3 cycles later -> one pulse on all 5 w_en; axi_id=0x105, axi_write=1.
- Single read: AR (id=0x0A, addr=0x2000, size=2) -> 4 strobes with data_w_en=0; axi_id=0x00A, axi_size=2.
- Contention: write and read ready on the same cycle for 4 consecutive requests each -> pushes alternate W,R,W,R,... starting with W.
- Full bypass: data_fifo_full=1 with a write and a read pending -> read pushed, write held and wready stalls. Release full -> write pushed next cycle.
- Backpressure: addr_fifo_full=1 for 10 cycles -> no strobes; awready/arready drop once the holds fill. No lost or duplicated entries after release.
- Error and reset: awlen=3 -> err_burst=1 and a single push. Assert aresetn low mid-hold -> strobes and err_burst return to 0 and the holds are empty.
